hex_display_scanner: RTL and testbench
======================================

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, sets the number of multiplexed digits (2..8).
REQ-002 Parameter SCAN_DIV, default 50000, sets the clk cycles per digit slot (>= BLANK_CYCLES+2).
REQ-003 Parameter BLANK_CYCLES, default 16, sets the anti-ghost dead time at the start of each slot, in clk cycles.
REQ-004 Parameter SEG_ACTIVE_LOW, default 1, selects segment polarity: 1 = lit segment driven 0; 0 = all segment and dp outputs inverted.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 load  input  1  one-cycle strobe that captures data_in, dp_in and blank_lz.
REQ-008 data_in  input  4*NUM_DIGITS  hex nibbles; digit 0 (least significant) = data_in[3:0].
REQ-009 dp_in  input  NUM_DIGITS  per-digit decimal point request, 1 = lit.
REQ-010 blank_lz  input  1  enables leading-zero blanking.
REQ-011 seg_out  output  7  segments, bit6=g .. bit0=a.
REQ-012 dp_out  output  1  decimal point of the selected digit.
REQ-013 dig_sel  output  NUM_DIGITS  digit enables, active-low, at most one low at a time.
REQ-014 frame_done  output  1  one-cycle pulse when the last digit slot ends.

Function
REQ-015 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; its terminal count SHALL advance the digit index modulo NUM_DIGITS.
REQ-016 On load=1, inputs SHALL be captured into a shadow register and a pending flag SHALL be set; a further load while pending SHALL overwrite the shadow.
REQ-017 At the frame wrap (index NUM_DIGITS-1 -> 0), a pending shadow SHALL copy to the active register and pending SHALL clear; load on that same cycle SHALL win, landing in the shadow with pending still set.
REQ-018 frame_done SHALL pulse high for exactly the cycle in which the index wraps to 0.
REQ-019 Active-low codes (hex) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 B=03 C=27 D=21 E=06 F=0E; blank = 7F.
REQ-020 With blank_lz=1, every digit above the most significant non-zero nibble SHALL show blank with dp off unless its dp bit is set; digit 0 SHALL never be blanked.
REQ-021 During the first BLANK_CYCLES cycles of every slot, dig_sel SHALL be all ones; for the remainder of the slot, exactly bit[index] SHALL be 0.
REQ-022 seg_out, dp_out and dig_sel SHALL be registered with 1-cycle latency from the prescaler/index state; they SHALL change only at slot boundaries and at dead-time end.

Reset
REQ-023 While rst=0 at a clk edge, the following SHALL be forced: prescaler=0, index=0, active and shadow registers=0, pending=0, frame_done=0, dig_sel all ones, seg_out blank, dp_out off (polarity per SEG_ACTIVE_LOW).
REQ-024 Reset asserted mid-slot or mid-frame SHALL discard any pending load; the first slot after release SHALL be digit 0 with full dead time.

Structure
REQ-025 The segment code constants and the blank code SHALL reside in shared package hex_display_pkg.
REQ-026 Nibble-to-segment conversion SHALL be sub-module hex_seg_lut (combinational, 4-bit in, 7-bit active-low out); polarity inversion SHALL happen in the top level.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2)
REQ-027 Reset release, no load -> digit 0 lit with seg 40 in cycles 3..8, dig_sel=1110; frame_done pulses every 32 cycles.
REQ-028 load data_in=16'h12AF mid-frame -> display unchanged until the wrap; next frame shows 0E,08,24,79 on digits 0..3.
REQ-029 blank_lz=1, data_in=16'h0030, dp_in=4'b1000 -> digit3 shows 7F with dp lit, digit2 shows 7F with dp off, digit1 shows 30, digit0 shows 40.
REQ-030 Two loads, 16'h1111 then 16'h2222, in one frame -> only 2222 is displayed; load coincident with the wrap -> that value appears one frame later.
REQ-031 SEG_ACTIVE_LOW=0, data 8 -> seg_out=7F; rst=0 mid-slot for 1 cycle -> all outputs off, restart at digit 0 with zeros.
REQ-032 Continuous check -> never more than one dig_sel bit low; all ones in every dead-time window.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared segment encodings for the hex display scanner: active-low 7-segment codes, bit6=g .. bit0=a.
`default_nettype none

package hex_display_pkg;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_HEX_0 = 7'h40;
  localparam seg_code_t SEG_HEX_1 = 7'h79;
  localparam seg_code_t SEG_HEX_2 = 7'h24;
  localparam seg_code_t SEG_HEX_3 = 7'h30;
  localparam seg_code_t SEG_HEX_4 = 7'h19;
  localparam seg_code_t SEG_HEX_5 = 7'h12;
  localparam seg_code_t SEG_HEX_6 = 7'h02;
  localparam seg_code_t SEG_HEX_7 = 7'h78;
  localparam seg_code_t SEG_HEX_8 = 7'h00;
  localparam seg_code_t SEG_HEX_9 = 7'h18;
  localparam seg_code_t SEG_HEX_A = 7'h08;
  localparam seg_code_t SEG_HEX_B = 7'h03;
  localparam seg_code_t SEG_HEX_C = 7'h27;
  localparam seg_code_t SEG_HEX_D = 7'h21;
  localparam seg_code_t SEG_HEX_E = 7'h06;
  localparam seg_code_t SEG_HEX_F = 7'h0E;
  localparam seg_code_t SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/hex_seg_lut.sv
// Combinational nibble to active-low 7-segment code lookup.
`default_nettype none

module hex_seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_code_t  seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_n_o = SEG_HEX_0;
      4'h1: seg_n_o = SEG_HEX_1;
      4'h2: seg_n_o = SEG_HEX_2;
      4'h3: seg_n_o = SEG_HEX_3;
      4'h4: seg_n_o = SEG_HEX_4;
      4'h5: seg_n_o = SEG_HEX_5;
      4'h6: seg_n_o = SEG_HEX_6;
      4'h7: seg_n_o = SEG_HEX_7;
      4'h8: seg_n_o = SEG_HEX_8;
      4'h9: seg_n_o = SEG_HEX_9;
      4'hA: seg_n_o = SEG_HEX_A;
      4'hB: seg_n_o = SEG_HEX_B;
      4'hC: seg_n_o = SEG_HEX_C;
      4'hD: seg_n_o = SEG_HEX_D;
      4'hE: seg_n_o = SEG_HEX_E;
      4'hF: seg_n_o = SEG_HEX_F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner: prescaled digit scan with dead time, shadowed
// loads applied at frame wrap, leading-zero blanking and selectable segment polarity.
`default_nettype none

module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LIVE = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam seg_code_t     SEG_OFF  = SEG_ACTIVE_LOW ? SEG_BLANK : seg_code_t'(~SEG_BLANK);
  localparam logic          DP_OFF   = SEG_ACTIVE_LOW;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  w_slot_end, w_frame_wrap;

  logic [DW-1:0]         shd_data_q, act_data_q;
  logic [NUM_DIGITS-1:0] shd_dp_q, act_dp_q;
  logic                  shd_lz_q, act_lz_q, pend_q;

  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_zero_run;
  logic [3:0]            w_nib;
  logic                  w_blank, w_dp_req;
  seg_code_t             w_lut_seg, w_seg_n;

  seg_code_t             seg_d, seg_q;
  logic                  dp_d, dp_q;
  logic [NUM_DIGITS-1:0] dig_sel_d, dig_sel_q;
  logic                  frame_done_q;

  always_comb begin
    w_slot_end   = (cnt_q == CNT_LAST);
    w_frame_wrap = w_slot_end && (idx_q == IDX_LAST);
    cnt_d        = w_slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (w_slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is blanked when it and every digit above it hold zero; digit 0 never is.
  always_comb begin
    w_lz_mask  = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_run   = w_zero_run & (act_data_q[4*i +: 4] == 4'h0);
      w_lz_mask[i] = act_lz_q & w_zero_run;
    end
  end

  always_comb begin
    w_nib    = act_data_q[3:0];
    w_blank  = 1'b0;
    w_dp_req = act_dp_q[0];
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_nib    = act_data_q[4*i +: 4];
        w_blank  = w_lz_mask[i];
        w_dp_req = act_dp_q[i];
      end
    end
  end

  hex_seg_lut u_lut (
    .nibble_i (w_nib),
    .seg_n_o  (w_lut_seg)
  );

  assign w_seg_n = w_blank ? SEG_BLANK : w_lut_seg;

  if (SEG_ACTIVE_LOW) begin : g_active_low
    assign seg_d = w_seg_n;
    assign dp_d  = ~w_dp_req;
  end else begin : g_active_high
    assign seg_d = ~w_seg_n;
    assign dp_d  = w_dp_req;
  end

  always_comb begin
    dig_sel_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_sel_d[i] = !((cnt_q >= CNT_LIVE) && (idx_q == IW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      shd_lz_q     <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_lz_q     <= 1'b0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      dig_sel_q    <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= w_frame_wrap;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_sel_q    <= dig_sel_d;
      if (w_frame_wrap && pend_q) begin
        act_data_q <= shd_data_q;
        act_dp_q   <= shd_dp_q;
        act_lz_q   <= shd_lz_q;
      end
      // A load coinciding with the wrap stays pending for the following frame.
      if (load) begin
        shd_data_q <= data_in;
        shd_dp_q   <= dp_in;
        shd_lz_q   <= blank_lz;
        pend_q     <= 1'b1;
      end else if (w_frame_wrap) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: frame-level reference model feeds expected digits to a monitor.
`default_nettype none

module tb_hex_display_scanner;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  seg_lo, seg_hi;
  logic        dp_lo, dp_hi, fd_lo, fd_hi;
  logic [3:0]  dig_lo, dig_hi;

  hex_display_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_out(seg_lo), .dp_out(dp_lo), .dig_sel(dig_lo),
    .frame_done(fd_lo)
  );

  hex_display_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_out(seg_hi), .dp_out(dp_hi), .dig_sel(dig_hi),
    .frame_done(fd_hi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
  } content_t;

  typedef struct packed {
    logic [1:0] digit;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic [6:0] hex_code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  exp_t     sb_q[$];
  content_t latest;
  int       n = -1;
  int       passed = 0;
  int       total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, n);
  endfunction

  // Expected digits of one frame, straight from the display rules.
  function automatic void push_frame(content_t c);
    int msnz = 0;
    for (int d = 0; d < ND; d++) begin
      if (c.data[4*d +: 4] != 4'h0) msnz = d;
    end
    for (int d = 0; d < ND; d++) begin
      exp_t e;
      e.digit = d[1:0];
      e.seg   = (c.lz && d > msnz) ? 7'h7F : hex_code[c.data[4*d +: 4]];
      e.dp    = c.dp[d];
      sb_q.push_back(e);
    end
  endfunction

  // Content shown in a frame is the latest load sampled strictly before that frame's wrap edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      n      = 0;
      latest = '0;
      sb_q.delete();
      push_frame('0);
    end else begin
      n++;
      if (n % FRAME == 0) push_frame(latest);
      if (load) latest = {data_in, dp_in, blank_lz};
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] p, logic lz);
    data_in  = d;
    dp_in    = p;
    blank_lz = lz;
    load     = 1'b1;
    tick();
  endtask

  exp_t       cur;
  bit         cur_ok = 1'b0;
  bit         prev_lit = 1'b0;
  bit         mon_dead;
  logic [3:0] exp_sel;
  logic [6:0] exp_seg_hi;

  always @(negedge clk) begin
    if (n == 0) begin
      chk("rst_sel", dig_lo, 4'hF);
      chk("rst_seg", seg_lo, 7'h7F);
      chk("rst_dp", dp_lo, 1'b1);
      chk("rst_fd", fd_lo, 1'b0);
      chk("rst_sel_hi", dig_hi, 4'hF);
      chk("rst_seg_hi", seg_hi, 7'h00);
      chk("rst_dp_hi", dp_hi, 1'b0);
      prev_lit = 1'b0;
    end else if (n > 0) begin
      mon_dead = ((n - 1) % SD) < BC;
      chk("frame_done", fd_lo, (n % FRAME) == 0);
      chk("frame_done_hi", fd_hi, (n % FRAME) == 0);
      chk("one_low", $countones(~dig_lo) <= 1, 1'b1);
      if (mon_dead) begin
        chk("dead_sel", dig_lo, 4'hF);
        chk("dead_sel_hi", dig_hi, 4'hF);
      end else begin
        if (!prev_lit) begin
          if (sb_q.size() == 0) begin
            cur_ok = 1'b0;
            total++;
            $display("FAIL sb_empty: got 0 expected entries, want >=1 (edge %0d)", n);
          end else begin
            cur    = sb_q.pop_front();
            cur_ok = 1'b1;
          end
        end
        if (cur_ok) begin
          exp_sel    = ~(4'b0001 << cur.digit);
          exp_seg_hi = ~cur.seg;
          chk("dig_sel", dig_lo, exp_sel);
          chk("seg", seg_lo, cur.seg);
          chk("dp", dp_lo, !cur.dp);
          chk("dig_sel_hi", dig_hi, exp_sel);
          chk("seg_hi", seg_hi, exp_seg_hi);
          chk("dp_hi", dp_hi, cur.dp);
        end
      end
      prev_lit = !mon_dead;
    end
  end

  logic [15:0] rnd_data;
  int          rnd_shift;

  initial begin
    rst = 1'b0;
    run(3);
    rst = 1'b1;
    run(70);

    while (n % FRAME != 10) tick();
    do_load(16'h12AF, 4'b0000, 1'b0);
    run(80);

    do_load(16'h0030, 4'b1000, 1'b1);
    run(80);

    while (n % FRAME != 5) tick();
    do_load(16'h1111, 4'b0001, 1'b0);
    run(6);
    do_load(16'h2222, 4'b0010, 1'b0);
    run(70);

    while ((n + 1) % FRAME != 0) tick();
    do_load(16'h5A5A, 4'b0101, 1'b0);
    run(70);

    do_load(16'h8888, 4'b1111, 1'b0);
    run(70);

    while (n % FRAME != 8) tick();
    do_load(16'hBEEF, 4'b1010, 1'b1);
    run(3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    run(70);

    for (int k = 0; k < 40; k++) begin
      run($urandom_range(0, 40));
      rnd_data  = 16'($urandom);
      rnd_shift = $urandom_range(0, 3);
      do_load(rnd_data >> (4 * rnd_shift), 4'($urandom), 1'($urandom_range(0, 1)));
    end
    run(70);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
